// File: rtl/dcache_store_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dcache_store_arbiter_pkg
// Shared types and helpers for the D$ store-port arbiter.
//   arb_state_e  : arbiter FSM state (IDLE / LOCKED)
//   DEF_*        : default configuration widths used as module defaults
//   wrap_inc()   : round-robin pointer increment with an explicit wrap compare,
//                  so non power-of-two port counts wrap correctly
// -----------------------------------------------------------------------------
package dcache_store_arbiter_pkg;

    localparam int unsigned DEF_NR_PORTS  = 3;
    localparam int unsigned DEF_PLEN      = 56;
    localparam int unsigned DEF_XLEN      = 64;
    localparam int unsigned DEF_WID_WIDTH = 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // idx + 1 modulo n, written as a compare rather than bit truncation.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dcache_store_arbiter_if.sv
// -----------------------------------------------------------------------------
// dcache_store_arbiter_if
// Bundles the requester-side vectors and the cache-side write request port.
//   Requester side : req_i, addr_i, wdata_i, be_i, size_i, wid_i (packed per
//                    port, port p in slice [p*W +: W]) and gnt_o (one-hot).
//   Cache side     : data_req_o + payload (addr_o, wdata_o, be_o, size_o,
//                    wid_o) and data_gnt_i.
// Handshake: a write transfers in the cycle where data_req_o and data_gnt_i are
// both high; the payload is held stable from the first cycle data_req_o rises
// until that transfer (or until the owning requester drops its req).
// Modports: slave = arbiter view, master = the environment (requesters + cache).
// -----------------------------------------------------------------------------
interface dcache_store_arbiter_if #(
    parameter int unsigned NR_PORTS  = 3,
    parameter int unsigned PLEN      = 56,
    parameter int unsigned XLEN      = 64,
    parameter int unsigned WID_WIDTH = 1
);
    logic [NR_PORTS-1:0]           req_i;
    logic [NR_PORTS*PLEN-1:0]      addr_i;
    logic [NR_PORTS*XLEN-1:0]      wdata_i;
    logic [NR_PORTS*XLEN/8-1:0]    be_i;
    logic [NR_PORTS*2-1:0]         size_i;
    logic [NR_PORTS*WID_WIDTH-1:0] wid_i;
    logic [NR_PORTS-1:0]           gnt_o;

    logic                          data_req_o;
    logic [PLEN-1:0]               addr_o;
    logic [XLEN-1:0]               wdata_o;
    logic [XLEN/8-1:0]             be_o;
    logic [1:0]                    size_o;
    logic [WID_WIDTH-1:0]          wid_o;
    logic                          data_gnt_i;

    modport slave (
        input  req_i, addr_i, wdata_i, be_i, size_i, wid_i, data_gnt_i,
        output gnt_o, data_req_o, addr_o, wdata_o, be_o, size_o, wid_o
    );

    modport master (
        output req_i, addr_i, wdata_i, be_i, size_i, wid_i, data_gnt_i,
        input  gnt_o, data_req_o, addr_o, wdata_o, be_o, size_o, wid_o
    );
endinterface

// File: rtl/dcache_store_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// dcache_store_arbiter_rr_select
// Combinational round-robin first-one finder.
//   req_i    : request vector
//   rr_ptr_i : highest-priority index this cycle
//   winner_o : first set bit scanning rr_ptr_i, rr_ptr_i+1, ... mod NR_PORTS
//   any_o    : at least one request set
// -----------------------------------------------------------------------------
module dcache_store_arbiter_rr_select #(
    parameter int unsigned NR_PORTS = 3,
    parameter int unsigned IDX_W    = $clog2(NR_PORTS)
) (
    input  logic [NR_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]    rr_ptr_i,
    output logic [IDX_W-1:0]    winner_o,
    output logic                any_o
);
    int unsigned      idx;
    logic [IDX_W-1:0] idx_t;
    logic             found;

    assign any_o = |req_i;

    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        idx      = 0;
        idx_t    = '0;
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            idx = 32'(rr_ptr_i) + i;
            if (idx >= NR_PORTS) idx = idx - NR_PORTS;
            idx_t = IDX_W'(idx);
            if (!found && req_i[idx_t]) begin
                winner_o = idx_t;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dcache_store_arbiter.sv
// -----------------------------------------------------------------------------
// dcache_store_arbiter
// Shares one D$ write request port between NR_PORTS requesters with
// round-robin arbitration and lock-until-grant.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   stall_i       : blocks new arbitration in IDLE; ignored while LOCKED
//   bus (slave)   : requester vectors, grant, cache request/payload/grant
//   busy_o        : lock held (state LOCKED)
//   abort_o       : one-cycle pulse, the cycle after the locked requester
//                   dropped its req without being granted
//   state_o       : FSM state (debug)
//   rr_ptr_o      : round-robin pointer (debug)
// Optional (macro DCACHE_STORE_ARB_PERF_EN):
//   perf_gnt_cnt_o      : per-port 32-bit saturating grant counters
//   perf_conflict_cnt_o : saturating count of request cycles with >1 req bit
// -----------------------------------------------------------------------------
module dcache_store_arbiter
    import dcache_store_arbiter_pkg::*;
#(
    parameter int unsigned NR_PORTS  = DEF_NR_PORTS,
    parameter int unsigned PLEN      = DEF_PLEN,
    parameter int unsigned XLEN      = DEF_XLEN,
    parameter int unsigned WID_WIDTH = DEF_WID_WIDTH,
    localparam int unsigned IDX_W    = $clog2(NR_PORTS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    dcache_store_arbiter_if.slave bus,
    output logic                 busy_o,
    output logic                 abort_o,
    output arb_state_e           state_o,
    output logic [IDX_W-1:0]     rr_ptr_o
`ifdef DCACHE_STORE_ARB_PERF_EN
    ,
    output logic [NR_PORTS*32-1:0] perf_gnt_cnt_o,
    output logic [31:0]            perf_conflict_cnt_o
`endif
);
    typedef struct packed {
        logic [PLEN-1:0]      addr;
        logic [XLEN-1:0]      wdata;
        logic [XLEN/8-1:0]    be;
        logic [1:0]           size;
        logic [WID_WIDTH-1:0] wid;
    } store_arb_req_t;

    arb_state_e       state_q;
    logic [IDX_W-1:0] rr_ptr_q, lock_q, winner, sel_idx;
    logic             any_req, abort_q, data_req;
    logic [NR_PORTS-1:0] gnt;
    store_arb_req_t   port_req [NR_PORTS];
    store_arb_req_t   sel_req;

    dcache_store_arbiter_rr_select #(
        .NR_PORTS (NR_PORTS),
        .IDX_W    (IDX_W)
    ) i_rr_select (
        .req_i    (bus.req_i),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (winner),
        .any_o    (any_req)
    );

    always_comb begin
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            port_req[i].addr  = bus.addr_i[i*PLEN +: PLEN];
            port_req[i].wdata = bus.wdata_i[i*XLEN +: XLEN];
            port_req[i].be    = bus.be_i[i*(XLEN/8) +: XLEN/8];
            port_req[i].size  = bus.size_i[i*2 +: 2];
            port_req[i].wid   = bus.wid_i[i*WID_WIDTH +: WID_WIDTH];
        end
    end

    // While LOCKED the owner stays selected so the payload cannot change
    // under a waiting request.
    assign sel_idx = (state_q == LOCKED) ? lock_q : winner;
    assign sel_req = port_req[sel_idx];

    // Zero-latency request path; reset forces the cache request low.
    always_comb begin
        data_req = 1'b0;
        if (!rst_i) begin
            if (state_q == LOCKED) data_req = bus.req_i[lock_q];
            else                   data_req = !stall_i && any_req;
        end
    end

    always_comb begin
        gnt = '0;
        if (data_req && bus.data_gnt_i) gnt[sel_idx] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            lock_q   <= '0;
            abort_q  <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!stall_i && any_req) begin
                        if (bus.data_gnt_i) begin
                            rr_ptr_q <= IDX_W'(wrap_inc(32'(winner), NR_PORTS));
                        end else begin
                            lock_q  <= winner;
                            state_q <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (!bus.req_i[lock_q]) begin
                        // Owner withdrew without a grant: drop lock, keep pointer.
                        abort_q <= 1'b1;
                        state_q <= IDLE;
                    end else if (bus.data_gnt_i) begin
                        rr_ptr_q <= IDX_W'(wrap_inc(32'(lock_q), NR_PORTS));
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data_req_o = data_req;
    assign bus.gnt_o      = gnt;
    assign bus.addr_o     = sel_req.addr;
    assign bus.wdata_o    = sel_req.wdata;
    assign bus.be_o       = sel_req.be;
    assign bus.size_o     = sel_req.size;
    assign bus.wid_o      = sel_req.wid;

    assign busy_o   = (state_q == LOCKED);
    assign abort_o  = abort_q;
    assign state_o  = state_q;
    assign rr_ptr_o = rr_ptr_q;

`ifdef DCACHE_STORE_ARB_PERF_EN
    logic [31:0] perf_gnt_q [NR_PORTS];
    logic [31:0] perf_conf_q;
    logic        multi_req;

    // x & (x-1) clears the lowest set bit; non-zero means two or more set.
    assign multi_req = |(bus.req_i & (bus.req_i - NR_PORTS'(1)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_conf_q <= '0;
            for (int unsigned i = 0; i < NR_PORTS; i++) perf_gnt_q[i] <= '0;
        end else begin
            if (data_req && multi_req && perf_conf_q != '1) perf_conf_q <= perf_conf_q + 32'd1;
            for (int unsigned i = 0; i < NR_PORTS; i++) begin
                if (gnt[i] && perf_gnt_q[i] != '1) perf_gnt_q[i] <= perf_gnt_q[i] + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < NR_PORTS; g++) begin : g_perf_out
        assign perf_gnt_cnt_o[g*32 +: 32] = perf_gnt_q[g];
    end
    assign perf_conflict_cnt_o = perf_conf_q;
`endif
endmodule

// File: tb/tb_dcache_store_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dcache_store_arbiter
// Self-checking bench for dcache_store_arbiter (3 ports). A reference model of
// the arbitration rules runs on every falling edge next to a per-cycle
// compare; directed sequences add hand-computed literal expectations.
// Optional counters are checked when DCACHE_STORE_ARB_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_dcache_store_arbiter;
    import dcache_store_arbiter_pkg::*;

    localparam int unsigned N    = 3;
    localparam int unsigned PLEN = 56;
    localparam int unsigned XLEN = 64;
    localparam int unsigned WIDW = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_i, stall_i;
    always #5 clk = ~clk;

    dcache_store_arbiter_if #(.NR_PORTS(N), .PLEN(PLEN), .XLEN(XLEN), .WID_WIDTH(WIDW)) bus ();

    logic       busy_o, abort_o;
    arb_state_e state_o;
    logic [1:0] rr_ptr_o;
`ifdef DCACHE_STORE_ARB_PERF_EN
    logic [N*32-1:0] perf_gnt;
    logic [31:0]     perf_conf;
`endif

    dcache_store_arbiter #(.NR_PORTS(N), .PLEN(PLEN), .XLEN(XLEN), .WID_WIDTH(WIDW)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .stall_i  (stall_i),
        .bus      (bus),
        .busy_o   (busy_o),
        .abort_o  (abort_o),
        .state_o  (state_o),
        .rr_ptr_o (rr_ptr_o)
`ifdef DCACHE_STORE_ARB_PERF_EN
        ,
        .perf_gnt_cnt_o      (perf_gnt),
        .perf_conflict_cnt_o (perf_conf)
`endif
    );

    // ---------------- payload per port ----------------
    logic [PLEN-1:0]   p_addr  [N];
    logic [XLEN-1:0]   p_wdata [N];
    logic [XLEN/8-1:0] p_be    [N];
    logic [1:0]        p_size  [N];
    logic [WIDW-1:0]   p_wid   [N];

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [N-1:0] exp_q[$];

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    bit          m_valid = 1'b0;
    bit          m_locked, m_abort;
    int          m_ptr, m_owner, m_sel;
    logic        e_req;
    logic [N-1:0] e_gnt;
    int          m_pg [N];
    int          m_conf;

    function automatic int first_from(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] r;
        r     = bus.req_i;
        e_req = 1'b0;
        e_gnt = '0;
        m_sel = 0;
        if (!rst_i) begin
            if (m_locked) begin
                m_sel = m_owner;
                e_req = r[m_owner];
            end else if (!stall_i && r != 0) begin
                m_sel = first_from(r, m_ptr);
                e_req = 1'b1;
            end
            if (e_req && bus.data_gnt_i) e_gnt = N'(1 << m_sel);
        end

        if (m_valid) begin
            check("data_req", 64'(bus.data_req_o), 64'(e_req));
            check("gnt",      64'(bus.gnt_o),      64'(e_gnt));
            check("busy",     64'(busy_o),         64'(m_locked));
            check("abort",    64'(abort_o),        64'(m_abort));
            check("rr_ptr",   64'(rr_ptr_o),       64'(m_ptr));
            if (e_req) begin
                check("addr",  64'(bus.addr_o),  64'(p_addr[m_sel]));
                check("wdata", bus.wdata_o,      p_wdata[m_sel]);
                check("be",    64'(bus.be_o),    64'(p_be[m_sel]));
                check("size",  64'(bus.size_o),  64'(p_size[m_sel]));
                check("wid",   64'(bus.wid_o),   64'(p_wid[m_sel]));
            end
        end

        // advance model to the state after the coming rising edge
        if (rst_i) begin
            m_valid  = 1'b1;
            m_locked = 1'b0;
            m_abort  = 1'b0;
            m_ptr    = 0;
            m_owner  = 0;
            m_conf   = 0;
            for (int i = 0; i < N; i++) m_pg[i] = 0;
        end else begin
            m_abort = 1'b0;
            if (e_req && $countones(r) > 1) m_conf++;
            if (e_gnt != 0) begin
                m_pg[m_sel]++;
                m_ptr    = (m_sel + 1) % N;
                m_locked = 1'b0;
            end else if (m_locked && !r[m_owner]) begin
                m_abort  = 1'b1;
                m_locked = 1'b0;
            end else if (!m_locked && e_req) begin
                m_locked = 1'b1;
                m_owner  = m_sel;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge; callers check literals
    // just after the following falling edge.
    task automatic drive(input logic [N-1:0] r, input logic st, input logic dg);
        @(posedge clk); #1;
        rst_i          = 1'b0;
        bus.req_i      = r;
        stall_i        = st;
        bus.data_gnt_i = dg;
        @(negedge clk); #1;
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        @(posedge clk); #1;
        rst_i          = 1'b1;
        bus.req_i      = r;
        stall_i        = 1'b0;
        bus.data_gnt_i = 1'b0;
        @(negedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_i          = 1'b1;
        stall_i        = 1'b0;
        bus.req_i      = '0;
        bus.data_gnt_i = 1'b0;
        p_addr[0] = 56'h800;  p_addr[1] = 56'h1000; p_addr[2] = 56'h2000;
        for (int i = 0; i < N; i++) begin
            p_wdata[i] = {$urandom, $urandom};
            p_be[i]    = 8'(8'h0F << i);
            p_size[i]  = 2'(i + 1);
            p_wid[i]   = 1'(i);
            bus.addr_i [i*PLEN +: PLEN]       = p_addr[i];
            bus.wdata_i[i*XLEN +: XLEN]       = p_wdata[i];
            bus.be_i   [i*(XLEN/8) +: XLEN/8] = p_be[i];
            bus.size_i [i*2 +: 2]             = p_size[i];
            bus.wid_i  [i*WIDW +: WIDW]       = p_wid[i];
        end
        repeat (2) @(posedge clk);

        // reset state
        drive(3'b000, 0, 0);
        check("rst_data_req", 64'(bus.data_req_o), 64'd0);
        check("rst_gnt",      64'(bus.gnt_o),      64'd0);
        check("rst_busy",     64'(busy_o),         64'd0);
        check("rst_rr_ptr",   64'(rr_ptr_o),       64'd0);

        // single port, same-cycle grant
        drive(3'b001, 0, 1);
        check("single_req", 64'(bus.data_req_o), 64'd1);
        check("single_gnt", 64'(bus.gnt_o),      64'b001);
        drive(3'b000, 0, 0);
        check("single_ptr",  64'(rr_ptr_o), 64'd1);
        check("single_busy", 64'(busy_o),   64'd0);

        // lock hold: port1 waits 3 cycles, port0 joins in cycle 2
        drive(3'b010, 0, 0);
        check("lock_addr0", 64'(bus.addr_o), 64'h1000);
        drive(3'b011, 0, 0);
        check("lock_addr1", 64'(bus.addr_o), 64'h1000);
        check("lock_busy1", 64'(busy_o),     64'd1);
        drive(3'b011, 0, 0);
        check("lock_addr2", 64'(bus.addr_o), 64'h1000);
        drive(3'b011, 0, 1);
        check("lock_gnt_p1", 64'(bus.gnt_o), 64'b010);
        drive(3'b001, 0, 1);
        check("lock_gnt_p0", 64'(bus.gnt_o), 64'b001);

        // fairness from a fresh pointer: 0,1,2,0,1,2
        do_reset(3'b000);
        for (int k = 0; k < 6; k++) exp_q.push_back(N'(1 << (k % 3)));
        for (int k = 0; k < 6; k++) begin
            drive(3'b111, 0, 1);
            check("fair_gnt", 64'(bus.gnt_o), 64'(exp_q.pop_front()));
        end

        // stall blocks IDLE, never an active lock
        drive(3'b111, 1, 1);
        check("stall_idle_req", 64'(bus.data_req_o), 64'd0);
        check("stall_idle_gnt", 64'(bus.gnt_o),      64'd0);
        drive(3'b100, 0, 0);
        drive(3'b100, 1, 0);
        check("stall_lock_req", 64'(bus.data_req_o), 64'd1);
        drive(3'b100, 1, 1);
        check("stall_lock_gnt", 64'(bus.gnt_o), 64'b100);
        drive(3'b000, 0, 0);
        check("wrap_ptr", 64'(rr_ptr_o), 64'd0);

        // data_gnt_i without a request is ignored
        drive(3'b000, 0, 1);
        check("lone_gnt", 64'(bus.gnt_o), 64'd0);

        // abort: move pointer to 2, lock port2, drop its req
        drive(3'b010, 0, 1);
        drive(3'b100, 0, 0);
        drive(3'b000, 0, 0);
        check("abort_gnt", 64'(bus.gnt_o), 64'd0);
        drive(3'b000, 0, 0);
        check("abort_pulse", 64'(abort_o),   64'd1);
        check("abort_state", 64'(state_o),   64'(IDLE));
        check("abort_ptr",   64'(rr_ptr_o),  64'd2);
        drive(3'b000, 0, 0);
        check("abort_once", 64'(abort_o), 64'd0);

        // reset while LOCKED (pointer 2 -> port0 wins)
        drive(3'b001, 0, 0);
        drive(3'b001, 0, 0);
        check("pre_rst_busy", 64'(busy_o), 64'd1);
        do_reset(3'b001);
        check("in_rst_req", 64'(bus.data_req_o), 64'd0);
        drive(3'b000, 0, 0);
        check("post_rst_busy",  64'(busy_o),         64'd0);
        check("post_rst_req",   64'(bus.data_req_o), 64'd0);
        check("post_rst_abort", 64'(abort_o),        64'd0);
        check("post_rst_ptr",   64'(rr_ptr_o),       64'd0);

        // contended grants for the counters, then mixed traffic
        for (int k = 0; k < 5; k++) drive(3'b111, 0, 1);
        for (int k = 0; k < 200; k++)
            drive(N'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        drive(3'b000, 0, 0);

`ifdef DCACHE_STORE_ARB_PERF_EN
        check("perf_conflict", 64'(perf_conf), 64'(m_conf));
        for (int i = 0; i < N; i++) check("perf_gnt", 64'(perf_gnt[i*32 +: 32]), 64'(m_pg[i]));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
